// File: rtl/instr_ram_loader.sv
// Boot loader for the instruction RAM: assembles a length-prefixed little-endian
// halfword stream into RAM writes, then hands the RAM address port to the CPU.
module instr_ram_loader #(
  parameter int NUM_INSTRUCTIONS = 4096,
  parameter int WORD = 32,
  parameter int HALF_WORD = 16,
  parameter logic [WORD-1:0] BASE_ADDR = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic                 byte_ready_o,
  input  logic [WORD-1:0]      pc_i,
  input  logic                 reload_i,
  output logic                 ram_write_en_o,
  output logic [HALF_WORD-1:0] ram_data_o,
  output logic [WORD-1:0]      ram_addr_o,
  output logic                 cpu_hold_o,
  output logic                 load_done_o,
  output logic                 overflow_o
);

  // state   | meaning
  // LEN_LO  | waiting for halfword-count low byte
  // LEN_HI  | waiting for halfword-count high byte
  // DATA_LO | waiting for low byte of next halfword
  // DATA_HI | waiting for high byte; acceptance launches a write
  // FLUSH   | final write drains while address still shows the pointer
  // RUN     | image loaded, RAM address follows the CPU PC
  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_FLUSH, S_RUN
  } state_t;

  localparam logic [WORD-1:0] CAPACITY = WORD'(NUM_INSTRUCTIONS);

  state_t          state, state_nxt;
  logic [WORD-1:0] ptr;
  logic [15:0]     remaining;
  logic [7:0]      lo_byte;
  logic            wr_en, adv, overflow, hold;
  logic [HALF_WORD-1:0] wr_data;
  logic            accept;
  logic [15:0]     count;
  logic [WORD-1:0] offset;
  logic            in_range;

  assign accept   = byte_valid_i && byte_ready_o;
  assign count    = {byte_i, lo_byte};
  assign offset   = ptr - BASE_ADDR;
  assign in_range = (offset >> 1) < CAPACITY;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_LEN_LO;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN_LO:  if (accept) state_nxt = S_LEN_HI;
      S_LEN_HI:  if (accept) state_nxt = (count == 16'd0) ? S_RUN : S_DATA_LO;
      S_DATA_LO: if (accept) state_nxt = S_DATA_HI;
      S_DATA_HI: if (accept) state_nxt = (remaining == 16'd1) ? S_FLUSH : S_DATA_LO;
      S_FLUSH:   state_nxt = S_RUN;
      S_RUN:     if (reload_i) state_nxt = S_LEN_LO;
      default:   state_nxt = S_LEN_LO;
    endcase
  end

  always_comb begin
    byte_ready_o   = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA_LO) || (state == S_DATA_HI);
    load_done_o    = (state == S_RUN);
    ram_addr_o     = (state == S_RUN) ? pc_i : ptr;
    ram_write_en_o = wr_en;
    ram_data_o     = wr_data;
    cpu_hold_o     = hold;
    overflow_o     = overflow;
  end

  // The pointer only moves in DATA_HI-launched cycles, so its value at byte
  // acceptance equals its value during the write; the range check uses it early.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr       <= BASE_ADDR;
      remaining <= '0;
      lo_byte   <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      adv       <= 1'b0;
      overflow  <= 1'b0;
      hold      <= 1'b1;
    end else begin
      wr_en <= 1'b0;
      adv   <= 1'b0;
      hold  <= (state_nxt != S_RUN);
      if (adv) ptr <= ptr + WORD'(2);
      case (state)
        S_LEN_LO:  if (accept) lo_byte <= byte_i;
        S_LEN_HI:  if (accept) remaining <= count;
        S_DATA_LO: if (accept) lo_byte <= byte_i;
        S_DATA_HI: begin
          if (accept) begin
            wr_data   <= {byte_i, lo_byte};
            adv       <= 1'b1;
            remaining <= remaining - 16'd1;
            if (in_range) wr_en    <= 1'b1;
            else          overflow <= 1'b1;
          end
        end
        S_RUN: begin
          if (reload_i) begin
            ptr      <= BASE_ADDR;
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_ram_loader.sv
// Randomized self-checking bench for instr_ram_loader; a full-size and a
// two-entry instance share one byte stream and are checked against a list model.
module tb_instr_ram_loader;
  logic        clk = 0, rst = 1, byte_valid = 0, reload = 0;
  logic [7:0]  byte_d = 0;
  logic [31:0] pc = 0;

  logic        ready_b, wen_b, hold_b, done_b, ovf_b;
  logic [15:0] data_b;
  logic [31:0] addr_b;
  logic        ready_s, wen_s, hold_s, done_s, ovf_s;
  logic [15:0] data_s;
  logic [31:0] addr_s;

  instr_ram_loader #(.NUM_INSTRUCTIONS(4096)) dut (
    .clk_i(clk), .rst_i(rst), .byte_valid_i(byte_valid), .byte_i(byte_d),
    .byte_ready_o(ready_b), .pc_i(pc), .reload_i(reload),
    .ram_write_en_o(wen_b), .ram_data_o(data_b), .ram_addr_o(addr_b),
    .cpu_hold_o(hold_b), .load_done_o(done_b), .overflow_o(ovf_b));

  instr_ram_loader #(.NUM_INSTRUCTIONS(2)) dut_s (
    .clk_i(clk), .rst_i(rst), .byte_valid_i(byte_valid), .byte_i(byte_d),
    .byte_ready_o(ready_s), .pc_i(pc), .reload_i(reload),
    .ram_write_en_o(wen_s), .ram_data_o(data_s), .ram_addr_o(addr_s),
    .cpu_hold_o(hold_s), .load_done_o(done_s), .overflow_o(ovf_s));

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [15:0] data; int cyc;} wr_t;
  wr_t wlog_b[$], wlog_s[$], exp_b[$], exp_s[$];
  int tests = 0, fails = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wen_b) wlog_b.push_back(wr_t'{addr_b, data_b, cyc});
    if (wen_s) wlog_s.push_back(wr_t'{addr_s, data_s, cyc});
  end

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int n;
    repeat ($urandom_range(gapmax)) begin
      @(negedge clk); byte_valid = 0; byte_d = 8'($urandom);
    end
    @(negedge clk); byte_valid = 1; byte_d = b;
    n = 0;
    while (!ready_b && n < 50) begin @(negedge clk); n++; end
    if (!ready_b) begin
      tests++; fails++;
      $display("FAIL send_byte_ready: got %0b want 1", ready_b);
    end
    @(posedge clk); #1 byte_valid = 0;
  endtask

  task automatic reload_pulse();
    @(negedge clk); reload = 1;
    @(posedge clk); #1 reload = 0;
  endtask

  // Model: halfword i lands at 2*i unless i is beyond the instance capacity.
  task automatic run_load(input int count, input int gapmax);
    logic [15:0] hw, c16;
    int n;
    c16 = 16'(count);
    exp_b.delete(); exp_s.delete(); wlog_b.delete(); wlog_s.delete();
    send_byte(c16[7:0], gapmax);
    send_byte(c16[15:8], gapmax);
    for (int i = 0; i < count; i++) begin
      hw = 16'($urandom);
      if (i < 4096) exp_b.push_back(wr_t'{32'(2 * i), hw, 0});
      if (i < 2)    exp_s.push_back(wr_t'{32'(2 * i), hw, 0});
      send_byte(hw[7:0], gapmax);
      send_byte(hw[15:8], gapmax);
    end
    n = 0;
    while (!done_b && n < 20) begin @(negedge clk); n++; end
    if (!done_b) begin
      tests++; fails++;
      $display("FAIL run_load_done: got %0b want 1", done_b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    tests++; if (ready_b !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b want 1", ready_b); end
    tests++; if (hold_b !== 1'b1) begin fails++; $display("FAIL reset_hold: got %0b want 1", hold_b); end
    tests++; if (done_b !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b want 0", done_b); end
    tests++; if (ovf_b !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %0b want 0", ovf_b); end
    tests++; if (wen_b !== 1'b0) begin fails++; $display("FAIL reset_wen: got %0b want 0", wen_b); end
    tests++; if (data_b !== 16'h0) begin fails++; $display("FAIL reset_data: got %h want 0000", data_b); end
    tests++; if (addr_b !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", addr_b); end
  endtask

  task automatic test_basic();
    logic [7:0] bytes [6];
    bytes = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    wlog_b.delete();
    for (int i = 0; i < 6; i++) send_byte(bytes[i], 0);
    @(negedge clk);
    tests++; if (ready_b !== 1'b0) begin fails++; $display("FAIL basic_flush_ready: got %0b want 0", ready_b); end
    tests++; if (hold_b !== 1'b1) begin fails++; $display("FAIL basic_flush_hold: got %0b want 1", hold_b); end
    tests++; if (addr_b !== 32'h2) begin fails++; $display("FAIL basic_flush_addr: got %h want 2", addr_b); end
    @(negedge clk);
    tests++; if (done_b !== 1'b1) begin fails++; $display("FAIL basic_run_done: got %0b want 1", done_b); end
    tests++; if (hold_b !== 1'b0) begin fails++; $display("FAIL basic_run_hold: got %0b want 0", hold_b); end
    pc = 32'h10; #1;
    tests++; if (addr_b !== 32'h10) begin fails++; $display("FAIL basic_pc_pass: got %h want 10", addr_b); end
    tests++;
    if (wlog_b.size() != 2) begin
      fails++; $display("FAIL basic_nwrites: got %0d want 2", wlog_b.size());
    end else begin
      if (wlog_b[0].addr !== 32'h0 || wlog_b[0].data !== 16'h1234) begin
        fails++; $display("FAIL basic_wr0: got %h@%h want 1234@0", wlog_b[0].data, wlog_b[0].addr);
      end
      tests++;
      if (wlog_b[1].addr !== 32'h2 || wlog_b[1].data !== 16'h5678) begin
        fails++; $display("FAIL basic_wr1: got %h@%h want 5678@2", wlog_b[1].data, wlog_b[1].addr);
      end
      tests++;
      if (wlog_b[1].cyc - wlog_b[0].cyc != 2) begin
        fails++; $display("FAIL basic_spacing: got %0d want 2", wlog_b[1].cyc - wlog_b[0].cyc);
      end
    end
  endtask

  task automatic test_zero_count();
    reload_pulse();
    wlog_b.delete();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    tests++; if (done_b !== 1'b1) begin fails++; $display("FAIL zero_done: got %0b want 1", done_b); end
    tests++; if (hold_b !== 1'b0) begin fails++; $display("FAIL zero_hold: got %0b want 0", hold_b); end
    repeat (3) @(negedge clk);
    tests++; if (wlog_b.size() != 0) begin fails++; $display("FAIL zero_writes: got %0d want 0", wlog_b.size()); end
  endtask

  task automatic test_gaps();
    reload_pulse();
    run_load(3, 3);
    tests++;
    if (wlog_b.size() != exp_b.size()) begin
      fails++; $display("FAIL gaps_nwrites: got %0d want %0d", wlog_b.size(), exp_b.size());
    end
    for (int i = 0; i < wlog_b.size() && i < exp_b.size(); i++) begin
      tests++;
      if (wlog_b[i].addr !== exp_b[i].addr || wlog_b[i].data !== exp_b[i].data) begin
        fails++; $display("FAIL gaps_wr%0d: got %h@%h want %h@%h", i,
                          wlog_b[i].data, wlog_b[i].addr, exp_b[i].data, exp_b[i].addr);
      end
    end
  endtask

  task automatic test_overflow();
    reload_pulse();
    run_load(3, 1);
    tests++;
    if (wlog_s.size() != exp_s.size()) begin
      fails++; $display("FAIL ovf_nwrites: got %0d want %0d", wlog_s.size(), exp_s.size());
    end
    for (int i = 0; i < wlog_s.size() && i < exp_s.size(); i++) begin
      tests++;
      if (wlog_s[i].addr !== exp_s[i].addr || wlog_s[i].data !== exp_s[i].data) begin
        fails++; $display("FAIL ovf_wr%0d: got %h@%h want %h@%h", i,
                          wlog_s[i].data, wlog_s[i].addr, exp_s[i].data, exp_s[i].addr);
      end
    end
    tests++; if (ovf_s !== 1'b1) begin fails++; $display("FAIL ovf_flag_small: got %0b want 1", ovf_s); end
    tests++; if (done_s !== 1'b1) begin fails++; $display("FAIL ovf_done_small: got %0b want 1", done_s); end
    tests++; if (ovf_b !== 1'b0) begin fails++; $display("FAIL ovf_flag_big: got %0b want 0", ovf_b); end
    tests++; if (wlog_b.size() != 3) begin fails++; $display("FAIL ovf_big_nwrites: got %0d want 3", wlog_b.size()); end
  endtask

  task automatic test_reload();
    @(negedge clk); reload = 1; byte_valid = 1; byte_d = 8'hAB;
    tests++; if (ready_b !== 1'b0) begin fails++; $display("FAIL reload_ready_run: got %0b want 0", ready_b); end
    @(posedge clk); #1 reload = 0; byte_valid = 0;
    @(negedge clk);
    tests++; if (hold_b !== 1'b1) begin fails++; $display("FAIL reload_hold: got %0b want 1", hold_b); end
    tests++; if (done_b !== 1'b0) begin fails++; $display("FAIL reload_done: got %0b want 0", done_b); end
    tests++; if (ovf_s !== 1'b0) begin fails++; $display("FAIL reload_ovf_clear: got %0b want 0", ovf_s); end
    tests++; if (ready_b !== 1'b1) begin fails++; $display("FAIL reload_ready: got %0b want 1", ready_b); end
    run_load(2, 1);
    tests++;
    if (wlog_b.size() != exp_b.size()) begin
      fails++; $display("FAIL reload_nwrites: got %0d want %0d", wlog_b.size(), exp_b.size());
    end
    for (int i = 0; i < wlog_b.size() && i < exp_b.size(); i++) begin
      tests++;
      if (wlog_b[i].addr !== exp_b[i].addr || wlog_b[i].data !== exp_b[i].data) begin
        fails++; $display("FAIL reload_wr%0d: got %h@%h want %h@%h", i,
                          wlog_b[i].data, wlog_b[i].addr, exp_b[i].data, exp_b[i].addr);
      end
    end
  endtask

  task automatic test_reset_midload();
    reload_pulse();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    wlog_b.delete();
    @(negedge clk); rst = 1; byte_valid = 1; byte_d = 8'h22;
    @(posedge clk); #1 rst = 0; byte_valid = 0;
    @(negedge clk);
    tests++; if (wen_b !== 1'b0) begin fails++; $display("FAIL midrst_wen: got %0b want 0", wen_b); end
    tests++; if (hold_b !== 1'b1) begin fails++; $display("FAIL midrst_hold: got %0b want 1", hold_b); end
    tests++; if (addr_b !== 32'h0) begin fails++; $display("FAIL midrst_addr: got %h want 0", addr_b); end
    tests++; if (ready_b !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %0b want 1", ready_b); end
    repeat (3) @(negedge clk);
    tests++; if (wlog_b.size() != 0) begin fails++; $display("FAIL midrst_writes: got %0d want 0", wlog_b.size()); end
    run_load(1, 0);
    tests++;
    if (wlog_b.size() != 1) begin
      fails++; $display("FAIL midrst_nwrites: got %0d want 1", wlog_b.size());
    end else if (wlog_b[0].addr !== exp_b[0].addr || wlog_b[0].data !== exp_b[0].data) begin
      fails++; $display("FAIL midrst_wr0: got %h@%h want %h@%h",
                        wlog_b[0].data, wlog_b[0].addr, exp_b[0].data, exp_b[0].addr);
    end
  endtask

  task automatic test_random();
    int cnt;
    for (int k = 0; k < 5; k++) begin
      reload_pulse();
      cnt = $urandom_range(6);
      run_load(cnt, 2);
      tests++;
      if (wlog_b.size() != exp_b.size() || wlog_s.size() != exp_s.size()) begin
        fails++; $display("FAIL rand%0d_nwrites: got %0d/%0d want %0d/%0d", k,
                          wlog_b.size(), wlog_s.size(), exp_b.size(), exp_s.size());
      end
      for (int i = 0; i < wlog_b.size() && i < exp_b.size(); i++) begin
        tests++;
        if (wlog_b[i].addr !== exp_b[i].addr || wlog_b[i].data !== exp_b[i].data) begin
          fails++; $display("FAIL rand%0d_wr%0d: got %h@%h want %h@%h", k, i,
                            wlog_b[i].data, wlog_b[i].addr, exp_b[i].data, exp_b[i].addr);
        end
      end
      for (int i = 0; i < wlog_s.size() && i < exp_s.size(); i++) begin
        tests++;
        if (wlog_s[i].addr !== exp_s[i].addr || wlog_s[i].data !== exp_s[i].data) begin
          fails++; $display("FAIL rand%0d_small_wr%0d: got %h@%h want %h@%h", k, i,
                            wlog_s[i].data, wlog_s[i].addr, exp_s[i].data, exp_s[i].addr);
        end
      end
      tests++;
      if (ovf_s !== (cnt > 2)) begin
        fails++; $display("FAIL rand%0d_ovf: got %0b want %0b", k, ovf_s, (cnt > 2));
      end
      pc = $urandom; #1;
      tests++;
      if (addr_b !== pc) begin
        fails++; $display("FAIL rand%0d_pc_pass: got %h want %h", k, addr_b, pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_gaps();
    test_overflow();
    test_reload();
    test_reset_midload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
